mlp_layer_sequencer: RTL

//  Sequences the fc_layer chain of an MLP top (e.g. mlp_l_d2_c128_top, 5 layers).
//  Per layer: one FSM issues i_start (ibuf -> CIM write), waits for the CIM MVM, then

---
 rtl/mlp_layer_sequencer_if.sv | 30 +++
 rtl/mlp_layer_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer_if.sv
// Handshake bundle between the MLP layer sequencer and the fc_layer chain / frame source / sink.
// The sequencer side uses the master modport; the layer chain and environment use slave.
interface mlp_layer_sequencer_if #(
    parameter int NUM_LAYERS = 5,
    parameter int CNT_W      = 16
);
    logic                  i_frame_valid;
    logic                  o_frame_ready;
    logic [NUM_LAYERS-1:0] i_layer_busy;
    logic [NUM_LAYERS-1:0] i_cim_busy;
    logic [NUM_LAYERS-1:0] o_start;
    logic [NUM_LAYERS-1:0] o_func_start;
    logic                  i_out_ready;
    logic                  o_frame_done;
    logic [CNT_W-1:0]      o_frames_done;
    logic [NUM_LAYERS-1:0] o_timeout_err;
    logic                  o_idle;

    modport master (
        input  i_frame_valid, i_layer_busy, i_cim_busy, i_out_ready,
        output o_frame_ready, o_start, o_func_start, o_frame_done,
               o_frames_done, o_timeout_err, o_idle
    );

    modport slave (
        output i_frame_valid, i_layer_busy, i_cim_busy, i_out_ready,
        input  o_frame_ready, o_start, o_func_start, o_frame_done,
               o_frames_done, o_timeout_err, o_idle
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Per-layer start / func_start sequencing for an fc_layer chain, with ibuf_full tokens
// so each layer holds one frame in its CIM and one in its input buffer.
module mlp_layer_sequencer #(
    parameter int NUM_LAYERS   = 5,
    parameter int BUSY_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    mlp_layer_sequencer_if.master     bus
);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, W_LD_HI, W_LD_LO, W_CIM, FUNC_REQ, W_FN_HI, W_FN_LO
    } state_t;

    state_t                state_q [NUM_LAYERS];
    state_t                state_d [NUM_LAYERS];
    logic [TMO_W-1:0]      tmo_q   [NUM_LAYERS];
    logic [TMO_W-1:0]      tmo_d   [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] ibuf_full_q, ibuf_full_d, ibuf_set, ibuf_clr;
    logic [NUM_LAYERS-1:0] fn_done, dn_ready, err_set;
    logic [NUM_LAYERS-1:0] start_d, func_d;
    logic [NUM_LAYERS-1:0] start_q, func_q, err_q;
    logic                  done_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  frame_accept;
    logic                  all_idle;

    // A layer may issue its func phase only once the next layer's ibuf is free;
    // the last layer is gated by the sink instead.
    always_comb begin
        frame_accept = bus.i_frame_valid & ~ibuf_full_q[0];
        dn_ready     = ~(ibuf_full_q >> 1);
        dn_ready[NUM_LAYERS-1] = bus.i_out_ready;
        ibuf_clr = '0;
        fn_done  = '0;
        err_set  = '0;
        start_d  = '0;
        func_d   = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            state_d[k] = state_q[k];
            tmo_d[k]   = tmo_q[k];
            case (state_q[k])
                IDLE: begin
                    if (ibuf_full_q[k]) begin
                        state_d[k] = LOAD;
                        start_d[k] = 1'b1;
                    end
                end
                LOAD: begin
                    tmo_d[k]   = '0;
                    state_d[k] = W_LD_HI;
                end
                W_LD_HI: begin
                    if (bus.i_layer_busy[k]) begin
                        state_d[k] = W_LD_LO;
                    end else if (tmo_q[k] == TMO_LIM) begin
                        err_set[k]  = 1'b1;
                        ibuf_clr[k] = 1'b1;
                        state_d[k]  = W_CIM;
                    end else begin
                        tmo_d[k] = tmo_q[k] + TMO_W'(1);
                    end
                end
                W_LD_LO: begin
                    if (!bus.i_layer_busy[k]) begin
                        ibuf_clr[k] = 1'b1;
                        state_d[k]  = W_CIM;
                    end
                end
                W_CIM: begin
                    if (!bus.i_cim_busy[k]) state_d[k] = FUNC_REQ;
                end
                FUNC_REQ: begin
                    if (dn_ready[k]) begin
                        func_d[k]  = 1'b1;
                        tmo_d[k]   = '0;
                        state_d[k] = W_FN_HI;
                    end
                end
                W_FN_HI: begin
                    if (bus.i_layer_busy[k]) begin
                        state_d[k] = W_FN_LO;
                    end else if (tmo_q[k] == TMO_LIM) begin
                        err_set[k] = 1'b1;
                        fn_done[k] = 1'b1;
                        state_d[k] = IDLE;
                    end else begin
                        tmo_d[k] = tmo_q[k] + TMO_W'(1);
                    end
                end
                W_FN_LO: begin
                    if (!bus.i_layer_busy[k]) begin
                        fn_done[k] = 1'b1;
                        state_d[k] = IDLE;
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
        // Set wins over clear on the same token.
        ibuf_set    = (fn_done << 1) | NUM_LAYERS'(frame_accept);
        ibuf_full_d = ibuf_set | (ibuf_full_q & ~ibuf_clr);
    end

    always_comb begin
        all_idle = ~|ibuf_full_q;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (state_q[k] != IDLE) all_idle = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                state_q[k] <= IDLE;
                tmo_q[k]   <= '0;
            end
            ibuf_full_q <= '0;
            start_q     <= '0;
            func_q      <= '0;
            err_q       <= '0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                state_q[k] <= state_d[k];
                tmo_q[k]   <= tmo_d[k];
            end
            ibuf_full_q <= ibuf_full_d;
            start_q     <= start_d;
            func_q      <= func_d;
            err_q       <= err_q | err_set;
            done_q      <= fn_done[NUM_LAYERS-1];
            cnt_q       <= cnt_q + CNT_W'(fn_done[NUM_LAYERS-1]);
        end
    end

    assign bus.o_frame_ready = ~ibuf_full_q[0];
    assign bus.o_start       = start_q;
    assign bus.o_func_start  = func_q;
    assign bus.o_frame_done  = done_q;
    assign bus.o_frames_done = cnt_q;
    assign bus.o_timeout_err = err_q;
    assign bus.o_idle        = all_idle;
endmodule
